// File: rtl/minhash_pkg.sv
// rtl/minhash_pkg.sv - shared encodings, widths and FSM type for the minhash signature path
package minhash_pkg;

    localparam int DEFAULT_SIGNATURE_WIDTH = 32;
    localparam int DEFAULT_INDEX_WIDTH     = 10;
    localparam logic [31:0] DEFAULT_HASH_MULT = 32'h9E3779B1;

    localparam logic [2:0] BASE_A = 3'd0;
    localparam logic [2:0] BASE_C = 3'd1;
    localparam logic [2:0] BASE_G = 3'd2;
    localparam logic [2:0] BASE_T = 3'd3;
    localparam logic [2:0] BASE_N = 3'd4;

    typedef enum logic [1:0] {
        GEN_IDLE,
        GEN_RUN,
        GEN_FLUSH,
        GEN_DONE
    } gen_state_t;

    // Every code from BASE_N upward is an ambiguous call.
    function automatic logic is_ambiguous(input logic [2:0] b);
        return b >= BASE_N;
    endfunction

endpackage

// File: rtl/kmer_hash.sv
// rtl/kmer_hash.sv - two-stage registered multiplicative hash with emit/index sideband
module kmer_hash
    import minhash_pkg::*;
#(
    parameter int KMER_WIDTH      = 32,
    parameter int SIGNATURE_WIDTH = DEFAULT_SIGNATURE_WIDTH,
    parameter int INDEX_WIDTH     = DEFAULT_INDEX_WIDTH,
    parameter logic [SIGNATURE_WIDTH-1:0] HASH_MULT = SIGNATURE_WIDTH'(DEFAULT_HASH_MULT)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       emit,
    input  logic [KMER_WIDTH-1:0]      kmer,
    input  logic [INDEX_WIDTH-1:0]     index,
    output logic                       valid_out,
    output logic [SIGNATURE_WIDTH-1:0] signature_out,
    output logic [INDEX_WIDTH-1:0]     index_out
);

    logic                   s1_emit;
    logic [KMER_WIDTH-1:0]  s1_kmer;
    logic [INDEX_WIDTH-1:0] s1_index;

    // Only the low SIGNATURE_WIDTH bits of the product are kept, and those depend
    // only on the low SIGNATURE_WIDTH bits of each operand.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_emit       <= 1'b0;
            s1_kmer       <= '0;
            s1_index      <= '0;
            valid_out     <= 1'b0;
            signature_out <= '0;
            index_out     <= '0;
        end else begin
            s1_emit   <= emit;
            valid_out <= s1_emit;
            if (emit) begin
                s1_kmer  <= kmer;
                s1_index <= index;
            end
            if (s1_emit) begin
                signature_out <= SIGNATURE_WIDTH'(s1_kmer) * HASH_MULT;
                index_out     <= s1_index;
            end
        end
    end

endmodule

// File: rtl/kmer_signature_gen.sv
// rtl/kmer_signature_gen.sv - rolling K-mer former feeding signatures to the bottom-k sorter
module kmer_signature_gen
    import minhash_pkg::*;
#(
    parameter int K               = 16,
    parameter int SIGNATURE_WIDTH = DEFAULT_SIGNATURE_WIDTH,
    parameter int INDEX_WIDTH     = DEFAULT_INDEX_WIDTH,
    parameter logic [SIGNATURE_WIDTH-1:0] HASH_MULT = SIGNATURE_WIDTH'(DEFAULT_HASH_MULT)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       base_valid,
    output logic                       base_ready,
    input  logic [2:0]                 base_in,
    input  logic                       base_last,
    output logic                       valid_out,
    output logic [SIGNATURE_WIDTH-1:0] signature_out,
    output logic [INDEX_WIDTH-1:0]     index_out,
    output logic                       overflow,
    output logic                       done
);

    localparam int KW = 2 * K;
    localparam int PW = INDEX_WIDTH + 1;
    localparam logic [5:0]    FILL_MAX    = 6'(K);
    localparam logic [PW-1:0] POS_MAX     = '1;
    localparam logic [PW-1:0] K_OFFSET    = PW'(K - 1);
    localparam logic [63:0]   LAST_OK_POS = 64'((64'd1 << INDEX_WIDTH) + 64'(K) - 64'd2);

    gen_state_t             state;
    logic [KW-1:0]          window;
    logic [5:0]             fill;
    logic [PW-1:0]          pos;
    logic                   flush_cnt;
    logic                   emit_q;
    logic [INDEX_WIDTH-1:0] start_q;

    logic                   accept;
    logic                   is_n;
    logic                   kmer_full;
    logic                   emit;
    logic                   start_ovf;
    logic [INDEX_WIDTH-1:0] start_idx;

    assign accept    = base_valid && base_ready;
    assign is_n      = is_ambiguous(base_in);
    assign kmer_full = (fill >= FILL_MAX - 6'd1);
    assign emit      = accept && !is_n && kmer_full;
    assign start_ovf = 64'(pos) > LAST_OK_POS;
    assign start_idx = INDEX_WIDTH'(pos - K_OFFSET);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= GEN_IDLE;
            base_ready <= 1'b0;
            window     <= '0;
            fill       <= '0;
            pos        <= '0;
            flush_cnt  <= 1'b0;
            emit_q     <= 1'b0;
            start_q    <= '0;
            overflow   <= 1'b0;
            done       <= 1'b0;
        end else begin
            emit_q <= 1'b0;
            done   <= 1'b0;
            if (accept) begin
                window <= {window[KW-3:0], base_in[1:0]};
                fill   <= is_n ? 6'd0 : (kmer_full ? FILL_MAX : fill + 6'd1);
                // Saturating keeps start positions monotonic on very long sequences.
                if (pos != POS_MAX) pos <= pos + PW'(1);
                if (emit) begin
                    if (start_ovf) begin
                        overflow <= 1'b1;
                    end else begin
                        emit_q  <= 1'b1;
                        start_q <= start_idx;
                    end
                end
            end
            case (state)
                GEN_IDLE, GEN_RUN: begin
                    base_ready <= 1'b1;
                    if (accept) begin
                        state      <= base_last ? GEN_FLUSH : GEN_RUN;
                        base_ready <= !base_last;
                        flush_cnt  <= 1'b0;
                    end
                end
                GEN_FLUSH: begin
                    flush_cnt <= 1'b1;
                    if (flush_cnt) state <= GEN_DONE;
                end
                GEN_DONE: begin
                    done       <= 1'b1;
                    state      <= GEN_IDLE;
                    base_ready <= 1'b1;
                    window     <= '0;
                    fill       <= '0;
                    pos        <= '0;
                    overflow   <= 1'b0;
                end
                default: state <= GEN_IDLE;
            endcase
        end
    end

    kmer_hash #(
        .KMER_WIDTH      (KW),
        .SIGNATURE_WIDTH (SIGNATURE_WIDTH),
        .INDEX_WIDTH     (INDEX_WIDTH),
        .HASH_MULT       (HASH_MULT)
    ) u_hash (
        .clk           (clk),
        .rst_n         (rst_n),
        .emit          (emit_q),
        .kmer          (window),
        .index         (start_q),
        .valid_out     (valid_out),
        .signature_out (signature_out),
        .index_out     (index_out)
    );

endmodule

// File: tb/tb_kmer_signature_gen.sv
// tb/tb_kmer_signature_gen.sv - randomized self-checking bench for kmer_signature_gen
module tb_kmer_signature_gen;

    localparam int TK = 4;
    localparam logic [31:0] MULT = 32'h9E3779B1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        base_valid = 1'b0;
    logic        base_last = 1'b0;
    logic [2:0]  base_in = 3'd0;

    logic        rdy0, valid0, ovf0, done0;
    logic [31:0] sig0;
    logic [9:0]  idx0;
    logic        rdy1, valid1, ovf1, done1;
    logic [31:0] sig1;
    logic [1:0]  idx1;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int clash = 0;
    int iw_of[2] = '{10, 2};

    int          acc_cyc[$];
    logic [31:0] exp_sig[2][$];
    int          exp_idx[2][$];
    int          exp_at[2][$];
    bit          exp_ovf[2];
    logic [31:0] got_sig[2][$];
    int          got_idx[2][$];
    int          got_cyc[2][$];
    int          done_cyc[2][$];
    bit          tail_rdy[5];
    bit          tail_ovf[2][5];

    kmer_signature_gen #(.K(TK), .SIGNATURE_WIDTH(32), .INDEX_WIDTH(10)) dut0 (
        .clk(clk), .rst_n(rst_n), .base_valid(base_valid), .base_ready(rdy0),
        .base_in(base_in), .base_last(base_last), .valid_out(valid0),
        .signature_out(sig0), .index_out(idx0), .overflow(ovf0), .done(done0)
    );

    kmer_signature_gen #(.K(TK), .SIGNATURE_WIDTH(32), .INDEX_WIDTH(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .base_valid(base_valid), .base_ready(rdy1),
        .base_in(base_in), .base_last(base_last), .valid_out(valid1),
        .signature_out(sig1), .index_out(idx1), .overflow(ovf1), .done(done1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (valid0) begin
            got_sig[0].push_back(sig0); got_idx[0].push_back(int'(idx0)); got_cyc[0].push_back(cyc);
        end
        if (valid1) begin
            got_sig[1].push_back(sig1); got_idx[1].push_back(int'(idx1)); got_cyc[1].push_back(cyc);
        end
        if (done0) done_cyc[0].push_back(cyc);
        if (done1) done_cyc[1].push_back(cyc);
        if ((done0 && valid0) || (done1 && valid1)) clash++;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    task automatic clear_obs();
        for (int d = 0; d < 2; d++) begin
            got_sig[d].delete(); got_idx[d].delete(); got_cyc[d].delete(); done_cyc[d].delete();
        end
        acc_cyc.delete();
        clash = 0;
    endtask

    // Reference: every run of K consecutive unambiguous bases is one K-mer.
    task automatic model_seq(input logic [2:0] seq[$]);
        int run = 0;
        for (int d = 0; d < 2; d++) begin
            exp_sig[d].delete(); exp_idx[d].delete(); exp_at[d].delete(); exp_ovf[d] = 0;
        end
        for (int i = 0; i < seq.size(); i++) begin
            if (seq[i] >= 3'd4) begin
                run = 0;
            end else begin
                run++;
                if (run >= TK) begin
                    longint unsigned kmer = 0;
                    longint unsigned m = MULT;
                    int start = i - TK + 1;
                    for (int j = start; j <= i; j++) kmer = kmer * 4 + longint'(seq[j][1:0]);
                    for (int d = 0; d < 2; d++) begin
                        if (start > (1 << iw_of[d]) - 1) begin
                            exp_ovf[d] = 1;
                        end else begin
                            exp_sig[d].push_back(32'(kmer * m));
                            exp_idx[d].push_back(start);
                            exp_at[d].push_back(i);
                        end
                    end
                end
            end
        end
    endtask

    task automatic drive_seq(input logic [2:0] seq[$], input int gap_pct);
        int i = 0;
        int guard = 0;
        clear_obs();
        model_seq(seq);
        while (i < seq.size() && guard < 1000) begin
            @(negedge clk);
            guard++;
            if (int'($urandom_range(99)) < gap_pct) begin
                base_valid = 1'b0; base_in = 3'($urandom); base_last = 1'($urandom);
            end else begin
                base_valid = 1'b1; base_in = seq[i]; base_last = (i == seq.size() - 1);
                if (rdy0) begin
                    acc_cyc.push_back(cyc + 1);
                    i++;
                end
            end
        end
        if (i < seq.size()) begin
            vectors++; miscompares++;
            $display("FAIL drive_timeout: accepted %0d bases, required %0d", i, seq.size());
        end
        // Offer junk bases while flushing; none may be taken.
        for (int off = 0; off < 5; off++) begin
            @(negedge clk);
            tail_rdy[off] = rdy0; tail_ovf[0][off] = ovf0; tail_ovf[1][off] = ovf1;
            base_valid = (off < 2); base_in = 3'($urandom); base_last = 1'($urandom);
        end
    endtask

    task automatic check_seq(input string name);
        int alast = acc_cyc[acc_cyc.size() - 1];
        for (int d = 0; d < 2; d++) begin
            int n;
            vectors++;
            if (got_sig[d].size() != exp_sig[d].size()) begin
                miscompares++;
                $display("FAIL %s_count dut%0d: got %0d signatures, want %0d", name, d, got_sig[d].size(), exp_sig[d].size());
            end
            n = (got_sig[d].size() < exp_sig[d].size()) ? got_sig[d].size() : exp_sig[d].size();
            for (int i = 0; i < n; i++) begin
                int want_cyc = acc_cyc[exp_at[d][i]] + 2;
                vectors++;
                if (got_sig[d][i] !== exp_sig[d][i] || got_idx[d][i] != exp_idx[d][i] || got_cyc[d][i] != want_cyc) begin
                    miscompares++;
                    $display("FAIL %s_sig dut%0d #%0d: got %h@%0d cyc %0d, want %h@%0d cyc %0d", name, d, i,
                             got_sig[d][i], got_idx[d][i], got_cyc[d][i], exp_sig[d][i], exp_idx[d][i], want_cyc);
                end
            end
            vectors++;
            if (done_cyc[d].size() != 1 || done_cyc[d][0] != alast + 3) begin
                miscompares++;
                $display("FAIL %s_done dut%0d: got %0d pulses first at %0d, want 1 at %0d", name, d,
                         done_cyc[d].size(), (done_cyc[d].size() > 0) ? done_cyc[d][0] : -1, alast + 3);
            end
            vectors++;
            if (tail_ovf[d][2] !== exp_ovf[d] || tail_ovf[d][3] !== 1'b0) begin
                miscompares++;
                $display("FAIL %s_overflow dut%0d: got %0b then %0b, want %0b then 0", name, d, tail_ovf[d][2], tail_ovf[d][3], exp_ovf[d]);
            end
        end
        vectors++;
        if (tail_rdy[0] || tail_rdy[1] || tail_rdy[2] || !tail_rdy[3]) begin
            miscompares++;
            $display("FAIL %s_ready: got %0b%0b%0b%0b, want 0001", name, tail_rdy[0], tail_rdy[1], tail_rdy[2], tail_rdy[3]);
        end
        vectors++;
        if (clash != 0) begin
            miscompares++;
            $display("FAIL %s_done_clash: got %0d overlaps, want 0", name, clash);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; base_valid = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if ({rdy0, valid0, ovf0, done0, sig0, idx0, rdy1, valid1, ovf1, done1, sig1, idx1} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got rdy=%b v=%b o=%b d=%b sig=%h idx=%0d, want all 0", rdy0, valid0, ovf0, done0, sig0, idx0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if (rdy0 !== 1'b1 || rdy1 !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_ready: got %b/%b, want 1/1", rdy0, rdy1);
        end
    endtask

    task automatic test_single_kmer();
        logic [2:0] s[$];
        s = {3'd0, 3'd0, 3'd0, 3'd1};
        drive_seq(s, 0);
        check_seq("single");
        vectors++;
        if (got_sig[0].size() != 1 || got_sig[0][0] !== 32'h9E3779B1 || got_idx[0][0] != 0) begin
            miscompares++;
            $display("FAIL single_const: got %0d sigs first %h, want 1 sig 9e3779b1@0", got_sig[0].size(), got_sig[0][0]);
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0] s[$];
        s = {3'd0, 3'd0, 3'd0, 3'd1, 3'd0};
        drive_seq(s, 0);
        check_seq("two");
        vectors++;
        if (got_sig[0].size() != 2 || got_sig[0][0] !== 32'h9E3779B1 || got_sig[0][1] !== 32'h78DDE6C4 ||
            got_idx[0][1] != 1 || got_cyc[0][1] != got_cyc[0][0] + 1) begin
            miscompares++;
            $display("FAIL two_const: got %0d sigs %h %h, want 9e3779b1 then 78dde6c4 on consecutive cycles",
                     got_sig[0].size(), got_sig[0][0], got_sig[0][1]);
        end
    endtask

    task automatic test_n_resync();
        logic [2:0] s[$];
        s = {3'd0, 3'd1, 3'd4, 3'd0, 3'd0, 3'd0, 3'd2};
        drive_seq(s, 0);
        check_seq("nresync");
        vectors++;
        if (got_sig[0].size() != 1 || got_sig[0][0] !== 32'h3C6EF362 || got_idx[0][0] != 3) begin
            miscompares++;
            $display("FAIL nresync_const: got %0d sigs first %h@%0d, want 3c6ef362@3", got_sig[0].size(), got_sig[0][0], got_idx[0][0]);
        end
    endtask

    task automatic test_overflow();
        logic [2:0] s[$];
        s = {3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
        drive_seq(s, 0);
        check_seq("overflow");
        vectors++;
        if (got_sig[1].size() != 4 || got_idx[1][3] != 3 || tail_ovf[1][2] !== 1'b1 || tail_ovf[0][2] !== 1'b0) begin
            miscompares++;
            $display("FAIL overflow_const: got %0d sigs ovf=%b/%b, want 4 sigs ovf=0/1", got_sig[1].size(), tail_ovf[0][2], tail_ovf[1][2]);
        end
    endtask

    task automatic test_short_then_next();
        logic [2:0] s[$];
        s = {3'd0, 3'd1, 3'd2};
        drive_seq(s, 0);
        check_seq("short");
        s = {3'd3, 3'd3, 3'd2, 3'd1, 3'd0};
        drive_seq(s, 0);
        check_seq("after_short");
        s = {3'd0, 3'd1, 3'd2, 3'd3, 3'd5};
        drive_seq(s, 0);
        check_seq("n_last");
    endtask

    task automatic test_random();
        for (int t = 0; t < 14; t++) begin
            logic [2:0] s[$];
            int len = $urandom_range(1, 24);
            for (int i = 0; i < len; i++)
                s.push_back(($urandom_range(99) < 15) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3)));
            drive_seq(s, (t < 10) ? 30 : 0);
            check_seq("random");
        end
    endtask

    task automatic test_midstream_reset();
        logic [2:0] s[$];
        s = {3'd2, 3'd0, 3'd3, 3'd1};
        clear_obs();
        foreach (s[i]) begin
            @(negedge clk);
            base_valid = 1'b1; base_in = s[i]; base_last = 1'b0;
        end
        @(negedge clk);
        base_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (rdy0 !== 1'b0 || valid0 !== 1'b0 || sig0 !== '0 || idx0 !== '0 || ovf0 !== 1'b0) begin
            miscompares++;
            $display("FAIL midreset_outputs: got rdy=%b v=%b sig=%h idx=%0d, want all 0", rdy0, valid0, sig0, idx0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if (rdy0 !== 1'b1) begin
            miscompares++;
            $display("FAIL midreset_ready: got %b, want 1", rdy0);
        end
        repeat (6) @(negedge clk);
        vectors++;
        if (got_sig[0].size() != 0 || got_sig[1].size() != 0 || done_cyc[0].size() != 0 || done_cyc[1].size() != 0) begin
            miscompares++;
            $display("FAIL midreset_quiet: got %0d sigs %0d dones, want 0 and 0", got_sig[0].size(), done_cyc[0].size());
        end
        vectors++;
        if (sig0 !== '0 || idx0 !== '0 || ovf0 !== 1'b0 || sig1 !== '0 || ovf1 !== 1'b0) begin
            miscompares++;
            $display("FAIL midreset_hold: got sig=%h idx=%0d ovf=%b, want 0", sig0, idx0, ovf0);
        end
    endtask

    initial begin
        test_reset();
        test_single_kmer();
        test_back_to_back();
        test_n_resync();
        test_overflow();
        test_short_then_next();
        test_random();
        test_midstream_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
